// File: rtl/la_pkg.sv
// ----------------------------------------------------------------------------
// la_pkg
// Shared definitions for the logic-analyzer capture engine: the capture state
// encoding (as seen on state_o) and the trigger-mode encodings.
// ----------------------------------------------------------------------------
package la_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } la_state_e;

    localparam logic [1:0] TRIG_LEVEL = 2'b00;
    localparam logic [1:0] TRIG_RISE  = 2'b01;
    localparam logic [1:0] TRIG_FALL  = 2'b10;
    localparam logic [1:0] TRIG_ANY   = 2'b11;

endpackage

// File: rtl/la_capture_core_trig.sv
// ----------------------------------------------------------------------------
// la_trig_unit
// Trigger evaluator. Keeps the previously written sample and a flag telling
// whether that sample belongs to the current capture. It produces a
// combinational hit for the sample being written in the current cycle.
//
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset
//   clear_i   capture is being armed; invalidates the previous sample
//   sample_i  probe_i is being written to the buffer this cycle
//   probe_i   current probe sample
//   mode_i    latched trigger mode (level / rise / fall / any change)
//   mask_i    latched trigger mask
//   value_i   latched level-compare value
//   hit_o     trigger condition true for the current sample
// ----------------------------------------------------------------------------
module la_trig_unit
    import la_pkg::*;
#(
    parameter int unsigned PROBE_W = 35
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               sample_i,
    input  logic [PROBE_W-1:0] probe_i,
    input  logic [1:0]         mode_i,
    input  logic [PROBE_W-1:0] mask_i,
    input  logic [PROBE_W-1:0] value_i,
    output logic               hit_o
);

    logic [PROBE_W-1:0] prev_q;
    logic               prev_vld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else if (clear_i) begin
            prev_vld_q <= 1'b0;
        end else if (sample_i) begin
            prev_q     <= probe_i;
            prev_vld_q <= 1'b1;
        end
    end

    // Edge modes need a previous sample from this capture, so they can never
    // fire on the first sample after arming.
    always_comb begin
        hit_o = 1'b0;
        case (mode_i)
            TRIG_LEVEL: hit_o = (((probe_i ^ value_i) & mask_i) == '0);
            TRIG_RISE:  hit_o = prev_vld_q && (|(mask_i & ~prev_q & probe_i));
            TRIG_FALL:  hit_o = prev_vld_q && (|(mask_i & prev_q & ~probe_i));
            TRIG_ANY:   hit_o = prev_vld_q && (|(mask_i & (prev_q ^ probe_i)));
            default:    hit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/la_capture_core.sv
// ----------------------------------------------------------------------------
// la_capture_core
// In-fabric logic-analyzer capture engine. Samples probe_i every cycle into a
// circular buffer while capturing, stops DEPTH-1-pre_count samples after the
// trigger, and serves the capture oldest-first through a synchronous read port.
//
// Ports:
//   Clk           sample and logic clock
//   Reset_n       asynchronous active-low reset
//   probe_i       sampled bus
//   arm_i         start a capture (accepted in IDLE or DONE)
//   abort_i       return to IDLE from any state (beats arm and trigger)
//   trig_mode_i   trigger mode, latched at arm
//   trig_mask_i   trigger mask, latched at arm
//   trig_value_i  level compare value, latched at arm
//   pre_count_i   pre-trigger sample count, latched at arm
//   rd_en_i       read request
//   rd_addr_i     logical read index, 0 = oldest sample
//   rd_data_o     read data, one cycle after rd_en_i
//   rd_valid_o    rd_data_o is fresh (read issued while DONE)
//   state_o       current state encoding
//   triggered_o   trigger seen in the current capture
//   done_o        capture complete, buffer readable
// ----------------------------------------------------------------------------
module la_capture_core
    import la_pkg::*;
#(
    parameter int unsigned PROBE_W = 35,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned ADDR_W  = $clog2(DEPTH)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [PROBE_W-1:0] probe_i,
    input  logic               arm_i,
    input  logic               abort_i,
    input  logic [1:0]         trig_mode_i,
    input  logic [PROBE_W-1:0] trig_mask_i,
    input  logic [PROBE_W-1:0] trig_value_i,
    input  logic [ADDR_W-1:0]  pre_count_i,
    input  logic               rd_en_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    output logic [PROBE_W-1:0] rd_data_o,
    output logic               rd_valid_o,
    output logic [STATE_W-1:0] state_o,
    output logic               triggered_o,
    output logic               done_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    la_state_e          state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [PROBE_W-1:0] mask_q, mask_d;
    logic [PROBE_W-1:0] value_q, value_d;
    logic [ADDR_W-1:0]  pre_q, pre_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  start_ptr_q, start_ptr_d;
    logic               triggered_q, triggered_d;
    logic               rd_valid_q;
    logic [PROBE_W-1:0] rd_data_q;

    logic               wr_en;
    logic               arm_ok;
    logic               hit;
    logic [ADDR_W-1:0]  post_cnt;
    logic [ADDR_W-1:0]  rd_phys;

    logic [PROBE_W-1:0] mem_q [DEPTH];

    la_trig_unit #(
        .PROBE_W (PROBE_W)
    ) u_trig (
        .clk_i    (Clk),
        .rst_ni   (Reset_n),
        .clear_i  (arm_ok),
        .sample_i (wr_en),
        .probe_i  (probe_i),
        .mode_i   (mode_q),
        .mask_i   (mask_q),
        .value_i  (value_q),
        .hit_o    (hit)
    );

    // pre_count_i is ADDR_W wide, so it is already bounded to DEPTH-1.
    assign post_cnt = LAST_IDX - pre_q;

    // cnt_q counts writes done in PRE, and writes remaining in POST.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        mask_d      = mask_q;
        value_d     = value_q;
        pre_d       = pre_q;
        cnt_d       = cnt_q;
        start_ptr_d = start_ptr_q;
        triggered_d = triggered_q;
        wr_en       = 1'b0;
        arm_ok      = 1'b0;

        if (abort_i) begin
            state_d     = ST_IDLE;
            triggered_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_i) begin
                        arm_ok      = 1'b1;
                        mode_d      = trig_mode_i;
                        mask_d      = trig_mask_i;
                        value_d     = trig_value_i;
                        pre_d       = pre_count_i;
                        cnt_d       = '0;
                        triggered_d = 1'b0;
                        state_d     = (pre_count_i == '0) ? ST_WAIT : ST_PRE;
                    end
                end
                ST_PRE: begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + ONE;
                    if ((cnt_q + ONE) == pre_q) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wr_en = 1'b1;
                    if (hit) begin
                        triggered_d = 1'b1;
                        start_ptr_d = wr_ptr_q - pre_q;
                        cnt_d       = post_cnt;
                        state_d     = (post_cnt == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign wr_ptr_d = wr_en ? (wr_ptr_q + ONE) : wr_ptr_q;
    assign rd_phys  = start_ptr_q + rd_addr_i;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            mask_q      <= '0;
            value_q     <= '0;
            pre_q       <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            start_ptr_q <= '0;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            mask_q      <= mask_d;
            value_q     <= value_d;
            pre_q       <= pre_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            start_ptr_q <= start_ptr_d;
            triggered_q <= triggered_d;
            rd_valid_q  <= rd_en_i && (state_q == ST_DONE);
            if (rd_en_i && (state_q == ST_DONE)) begin
                rd_data_q <= mem_q[rd_phys];
            end
        end
    end

    // Buffer RAM: no reset so it can map onto block memory.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= probe_i;
        end
    end

    assign state_o     = state_q;
    assign triggered_o = triggered_q;
    assign done_o      = (state_q == ST_DONE);
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_la_capture_core.sv
module tb_la_capture_core;

    localparam int unsigned PW = 8;
    localparam int unsigned D  = 16;
    localparam int unsigned AW = 4;

    localparam logic [1:0] M_LEVEL = 2'b00;
    localparam logic [1:0] M_RISE  = 2'b01;
    localparam logic [1:0] M_ANY   = 2'b11;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b1;
    logic [PW-1:0] probe_i = '0;
    logic          arm_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [1:0]    trig_mode_i = '0;
    logic [PW-1:0] trig_mask_i = '0;
    logic [PW-1:0] trig_value_i = '0;
    logic [AW-1:0] pre_count_i = '0;
    logic          rd_en_i = 1'b0;
    logic [AW-1:0] rd_addr_i = '0;
    logic [PW-1:0] rd_data_o;
    logic          rd_valid_o;
    logic [2:0]    state_o;
    logic          triggered_o;
    logic          done_o;

    int total = 0;
    int bad   = 0;

    la_capture_core #(
        .PROBE_W (PW),
        .DEPTH   (D)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .probe_i      (probe_i),
        .arm_i        (arm_i),
        .abort_i      (abort_i),
        .trig_mode_i  (trig_mode_i),
        .trig_mask_i  (trig_mask_i),
        .trig_value_i (trig_value_i),
        .pre_count_i  (pre_count_i),
        .rd_en_i      (rd_en_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .state_o      (state_o),
        .triggered_o  (triggered_o),
        .done_o       (done_o)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic feed(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            probe_i = PW'(first + k);
            cyc();
        end
    endtask

    task automatic arm(input logic [1:0] mode, input logic [PW-1:0] mask,
                       input logic [PW-1:0] value, input logic [AW-1:0] pre);
        trig_mode_i  = mode;
        trig_mask_i  = mask;
        trig_value_i = value;
        pre_count_i  = pre;
        arm_i        = 1'b1;
        cyc();
        arm_i        = 1'b0;
    endtask

    task automatic read_all(input int base, input string tag);
        for (int i = 0; i < D; i++) begin
            rd_en_i   = 1'b1;
            rd_addr_i = AW'(i);
            cyc();
            check($sformatf("%s_valid[%0d]", tag, i), 32'(rd_valid_o), 32'd1);
            check($sformatf("%s_data[%0d]", tag, i), 32'(rd_data_o), 32'((base + i) & 8'hFF));
        end
        rd_en_i = 1'b0;
        cyc();
    endtask

    initial begin
        // Reset state
        #2 Reset_n = 1'b0;
        #1;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_trig", 32'(triggered_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_rdv", 32'(rd_valid_o), 32'd0);
        check("rst_rdd", 32'(rd_data_o), 32'd0);
        cyc();
        cyc();
        Reset_n = 1'b1;
        cyc();

        // 1: pre=4, level 0x0A
        arm(M_LEVEL, 8'hFF, 8'h0A, 4'd4);
        check("t1_pre", 32'(state_o), 32'd1);
        feed(0, 10);
        check("t1_wait", 32'(state_o), 32'd2);
        check("t1_notrig", 32'(triggered_o), 32'd0);
        feed(8'h0A, 1);
        check("t1_trig", 32'(triggered_o), 32'd1);
        check("t1_post", 32'(state_o), 32'd3);
        feed(8'h0B, 10);
        check("t1_done_early", 32'(done_o), 32'd0);
        feed(8'h15, 1);
        check("t1_done", 32'(done_o), 32'd1);
        check("t1_state_done", 32'(state_o), 32'd4);
        read_all(8'h06, "t1");

        // 2: pre=0, rising on bit 3, re-armed from DONE
        arm(M_RISE, 8'h08, 8'h00, 4'd0);
        check("t2_wait", 32'(state_o), 32'd2);
        check("t2_done_clr", 32'(done_o), 32'd0);
        feed(0, 8);
        check("t2_notrig", 32'(triggered_o), 32'd0);
        feed(8'h08, 1);
        check("t2_trig", 32'(triggered_o), 32'd1);
        feed(8'h09, 14);
        check("t2_done_early", 32'(done_o), 32'd0);
        feed(8'h17, 1);
        check("t2_done", 32'(done_o), 32'd1);
        read_all(8'h08, "t2");

        // 2b: first sample already has bit 3 set -> no edge trigger on it
        arm(M_RISE, 8'h08, 8'h00, 4'd0);
        feed(8'h08, 1);
        check("t2b_first", 32'(triggered_o), 32'd0);
        feed(8'h09, 15);
        check("t2b_hold", 32'(triggered_o), 32'd0);
        check("t2b_wait", 32'(state_o), 32'd2);
        feed(8'h18, 1);
        check("t2b_trig", 32'(triggered_o), 32'd1);
        check("t2b_post", 32'(state_o), 32'd3);
        feed(8'h19, 3);

        // 5: abort in POST, read ignored, then a normal capture
        abort_i = 1'b1;
        probe_i = 8'h1C;
        cyc();
        abort_i = 1'b0;
        check("t5_idle", 32'(state_o), 32'd0);
        check("t5_done", 32'(done_o), 32'd0);
        check("t5_trig", 32'(triggered_o), 32'd0);
        rd_en_i   = 1'b1;
        rd_addr_i = '0;
        cyc();
        rd_en_i = 1'b0;
        check("t5_rdv", 32'(rd_valid_o), 32'd0);
        check("t5_rdd_hold", 32'(rd_data_o), 32'h17);
        arm(M_LEVEL, 8'hFF, 8'h05, 4'd2);
        feed(0, 6);
        check("t5_trig2", 32'(triggered_o), 32'd1);
        feed(8'h06, 12);
        check("t5_done_early", 32'(done_o), 32'd0);
        feed(8'h12, 1);
        check("t5_done2", 32'(done_o), 32'd1);
        read_all(8'h03, "t5");

        // 3: pre=15, any change on bit 0 -> post_cnt=0
        arm(M_ANY, 8'h01, 8'h00, 4'd15);
        check("t3_pre", 32'(state_o), 32'd1);
        feed(0, 15);
        check("t3_wait", 32'(state_o), 32'd2);
        check("t3_notrig", 32'(triggered_o), 32'd0);
        feed(8'h0F, 1);
        check("t3_done", 32'(done_o), 32'd1);
        check("t3_trig", 32'(triggered_o), 32'd1);
        read_all(8'h00, "t3");

        // 4: long wait with wrap-around, arm ignored mid-capture
        arm(M_LEVEL, 8'hFF, 8'h30, 4'd4);
        feed(0, 8'h20);
        trig_value_i = 8'h21;
        pre_count_i  = 4'd0;
        arm_i        = 1'b1;
        probe_i      = 8'h20;
        cyc();
        arm_i = 1'b0;
        feed(8'h21, 15);
        check("t4_notrig", 32'(triggered_o), 32'd0);
        check("t4_wait", 32'(state_o), 32'd2);
        feed(8'h30, 1);
        check("t4_trig", 32'(triggered_o), 32'd1);
        check("t4_post", 32'(state_o), 32'd3);
        feed(8'h31, 10);
        check("t4_done_early", 32'(done_o), 32'd0);
        feed(8'h3B, 1);
        check("t4_done", 32'(done_o), 32'd1);
        read_all(8'h2C, "t4");

        // 6: asynchronous reset in WAIT, arm ignored while held
        arm(M_LEVEL, 8'hFF, 8'hFF, 4'd4);
        feed(0, 6);
        check("t6_wait", 32'(state_o), 32'd2);
        #2 Reset_n = 1'b0;
        #1;
        check("t6_state", 32'(state_o), 32'd0);
        check("t6_done", 32'(done_o), 32'd0);
        check("t6_trig", 32'(triggered_o), 32'd0);
        check("t6_rdv", 32'(rd_valid_o), 32'd0);
        check("t6_rdd", 32'(rd_data_o), 32'd0);
        arm_i = 1'b1;
        cyc();
        arm_i = 1'b0;
        check("t6_arm_held", 32'(state_o), 32'd0);
        Reset_n = 1'b1;
        cyc();
        check("t6_after", 32'(state_o), 32'd0);
        check("t6_after_done", 32'(done_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
